regfile_scb: RTL

REGFILE_SCB -- requirements
Module: regfile_scb

---
 rtl/regfile_scb_if.sv | 30 +++
 rtl/regfile_scb.sv | 127 ++++++++++++
 2 files changed

// File: rtl/regfile_scb_if.sv
// Bus bundle for regfile_scb: two read ports, one write port and the claim/scoreboard port.
// Parameters must match the regfile_scb instance that uses the slave modport.
interface regfile_scb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rr_1;
    logic [ADDR_W-1:0] rr_2;
    logic [DATA_W-1:0] rd_1;
    logic [DATA_W-1:0] rd_2;
    logic              rd_valid_1;
    logic              rd_valid_2;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;
    logic              reg_write;
    logic              claim;
    logic [ADDR_W-1:0] claim_reg;
    logic              claim_ok;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output rr_1, rr_2, wr, wd, reg_write, claim, claim_reg,
        input  rd_1, rd_2, rd_valid_1, rd_valid_2, claim_ok, pend_cnt
    );

    modport slave (
        input  rr_1, rr_2, wr, wd, reg_write, claim, claim_reg,
        output rd_1, rd_2, rd_valid_1, rd_valid_2, claim_ok, pend_cnt
    );
endinterface

// File: rtl/regfile_scb.sv
// Register file with two registered write-first read ports and a per-entry pending
// scoreboard: a claim marks an entry as awaiting a producer, a write to it clears the mark.
module regfile_scb #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_scb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [CNT_W-1:0]  pend_cnt_q;
    logic [CNT_W-1:0]  pend_cnt_d;
    logic [DATA_W-1:0] rd_1_q;
    logic [DATA_W-1:0] rd_1_d;
    logic [DATA_W-1:0] rd_2_q;
    logic [DATA_W-1:0] rd_2_d;
    logic              rd_valid_1_q;
    logic              rd_valid_1_d;
    logic              rd_valid_2_q;
    logic              rd_valid_2_d;

    logic wr_zero;
    logic claim_zero;
    logic write_en;
    logic claim_acc;
    logic clear_hit;

    // Entry 0 is inert when hardwired: no data write, no claim, never pending.
    always_comb begin
        wr_zero    = (ZERO_REG != 0) && (bus.wr == '0);
        claim_zero = (ZERO_REG != 0) && (bus.claim_reg == '0);
        write_en   = bus.reg_write && !wr_zero;
        claim_acc  = rst_n && bus.claim && !pend_q[bus.claim_reg] && !claim_zero;
        clear_hit  = bus.reg_write && pend_q[bus.wr];
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (write_en) begin
            mem_d[bus.wr] = bus.wd;
        end
    end

    // Clear before set: a same-entry claim is only accepted when the entry was idle,
    // so it must win; a rejected claim never reaches the set.
    always_comb begin
        pend_d = pend_q;
        if (bus.reg_write) begin
            pend_d[bus.wr] = 1'b0;
        end
        if (claim_acc) begin
            pend_d[bus.claim_reg] = 1'b1;
        end

        pend_cnt_d = pend_cnt_q;
        if (claim_acc && !clear_hit) begin
            pend_cnt_d = pend_cnt_q + CNT_W'(1);
        end else if (!claim_acc && clear_hit) begin
            pend_cnt_d = pend_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        rd_1_d       = mem_q[bus.rr_1];
        rd_valid_1_d = !pend_q[bus.rr_1];
        if ((ZERO_REG != 0) && (bus.rr_1 == '0)) begin
            rd_1_d       = '0;
            rd_valid_1_d = 1'b1;
        end else if (write_en && (bus.wr == bus.rr_1)) begin
            rd_1_d       = bus.wd;
            rd_valid_1_d = 1'b1;
        end

        rd_2_d       = mem_q[bus.rr_2];
        rd_valid_2_d = !pend_q[bus.rr_2];
        if ((ZERO_REG != 0) && (bus.rr_2 == '0)) begin
            rd_2_d       = '0;
            rd_valid_2_d = 1'b1;
        end else if (write_en && (bus.wr == bus.rr_2)) begin
            rd_2_d       = bus.wd;
            rd_valid_2_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (INIT_MODE != 0) ? DATA_W'(i) : '0;
            end
            pend_q       <= '0;
            pend_cnt_q   <= '0;
            rd_1_q       <= '0;
            rd_2_q       <= '0;
            rd_valid_1_q <= 1'b0;
            rd_valid_2_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            pend_q       <= pend_d;
            pend_cnt_q   <= pend_cnt_d;
            rd_1_q       <= rd_1_d;
            rd_2_q       <= rd_2_d;
            rd_valid_1_q <= rd_valid_1_d;
            rd_valid_2_q <= rd_valid_2_d;
        end
    end

    assign bus.claim_ok   = claim_acc;
    assign bus.rd_1       = rd_1_q;
    assign bus.rd_2       = rd_2_q;
    assign bus.rd_valid_1 = rd_valid_1_q;
    assign bus.rd_valid_2 = rd_valid_2_q;
    assign bus.pend_cnt   = pend_cnt_q;

endmodule
